// File: rtl/serial_frame_tx.sv
// Serializer: start bit, DATA_BITS payload LSB first, stop bit.
// Define PARITY_EN to insert an even-parity bit between data and stop.
module serial_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 C,
  input  logic                 clr,
  input  logic [DATA_BITS-1:0] D,
  input  logic                 load,
  output logic                 ready,
  output logic                 TX,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 done_q;
  logic                 cnt_last;
`ifdef PARITY_EN
  logic                 par_q;
`endif

  assign cnt_d    = cnt_q + CW'(1);
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge C) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (load) begin
            shift_q <= D;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            state_q <= S_START;
`ifdef PARITY_EN
            par_q   <= ^D;
`endif
          end
        end
        S_START: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DATA: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (bit_q == BIT_LAST) begin
`ifdef PARITY_EN
              tx_q    <= par_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              // next bit sits at [1] before the shift lands
              bit_q   <= bit_q + 4'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
`ifdef PARITY_EN
        S_PARITY: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
`endif
        S_STOP: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            // registered, so raise it one cycle ahead of the last
            cnt_q  <= cnt_d;
            done_q <= (cnt_q == CNT_PRE);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign TX    = tx_q;
  assign ready = ready_q;
  assign busy  = ~ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized bench for serial_frame_tx against a frame-level model.
// Honours PARITY_EN the same way as the design.
module tb_serial_frame_tx;

  localparam int CPB = 4;
  localparam int DB  = 8;
`ifdef PARITY_EN
  localparam int NB  = DB + 3;
`else
  localparam int NB  = DB + 2;
`endif
  localparam int NCYC = NB * CPB;

  logic         C;
  logic         clr;
  logic [DB-1:0] D;
  logic         load;
  logic         ready;
  logic         TX;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  serial_frame_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .C    (C),
    .clr  (clr),
    .D    (D),
    .load (load),
    .ready(ready),
    .TX   (TX),
    .busy (busy),
    .done (done)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  // Line level of bit slot idx within a frame carrying payload d.
  function automatic logic exp_bit(input logic [DB-1:0] d,
                                   input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return d[idx-1];
`ifdef PARITY_EN
    if (idx == DB + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic chk_idle(input string nm);
    n_tests++;
    if (TX !== 1'b1 || ready !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: tx=%b rdy=%b busy=%b done=%b want 1 1 0 0",
               nm, TX, ready, busy, done);
    end
  endtask

  task automatic start_frame(input logic [DB-1:0] d);
    @(negedge C);
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ready: got %b want 1", ready);
    end
    D    = d;
    load = 1'b1;
  endtask

  // Called right after the accepting edge; walks cycles 1..NCYC+1.
  task automatic check_frame(input logic [DB-1:0] d,
                             input bit keep,
                             input logic [DB-1:0] nd,
                             input int poke);
    logic et, ed, er;
    for (int t = 1; t <= NCYC + 1; t++) begin
      @(negedge C);
      if (t <= NCYC) begin
        et = exp_bit(d, (t - 1) / CPB);
        ed = (t == NCYC);
        er = 1'b0;
      end else begin
        et = 1'b1;
        ed = 1'b0;
        er = 1'b1;
      end
      n_tests++;
      if (TX !== et) begin
        n_fail++;
        $display("FAIL tx d=%h t=%0d: got %b want %b", d, t, TX, et);
      end
      n_tests++;
      if (done !== ed) begin
        n_fail++;
        $display("FAIL done d=%h t=%0d: got %b want %b",
                 d, t, done, ed);
      end
      n_tests++;
      if (ready !== er || busy !== ~er) begin
        n_fail++;
        $display("FAIL rdy d=%h t=%0d: got %b/%b want %b/%b",
                 d, t, ready, busy, er, ~er);
      end
      if (keep) begin
        load = 1'b1;
        D    = nd;
      end else if (t == poke) begin
        load = 1'b1;
        D    = 8'hFF;
      end else begin
        load = 1'b0;
        D    = DB'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    clr  = 1'b1;
    load = 1'b0;
    D    = '0;
    repeat (2) @(negedge C);
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge C);
      chk_idle("reset_idle");
    end
    clr  = 1'b1;
    load = 1'b1;
    D    = DB'($urandom);
    @(negedge C);
    chk_idle("clr_over_load");
    clr  = 1'b0;
    load = 1'b0;
    @(negedge C);
    chk_idle("after_clr_load");
  endtask

  task automatic test_single();
    start_frame(8'hA5);
    check_frame(8'hA5, 1'b0, '0, 0);
  endtask

  task automatic test_load_busy();
    start_frame(8'h0F);
    check_frame(8'h0F, 1'b0, '0, 10);
    start_frame(8'h3C);
    check_frame(8'h3C, 1'b0, '0, NCYC);
  endtask

  task automatic test_back_to_back();
    start_frame(8'h55);
    check_frame(8'h55, 1'b1, 8'h33, 0);
    check_frame(8'h33, 1'b0, '0, 0);
  endtask

  task automatic test_mid_reset();
    logic et;
    start_frame(8'h00);
    for (int t = 1; t <= 17; t++) begin
      @(negedge C);
      et = exp_bit(8'h00, (t - 1) / CPB);
      n_tests++;
      if (TX !== et || done !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_pre t=%0d: tx=%b done=%b want %b 0",
                 t, TX, done, et);
      end
      load = 1'b0;
    end
    clr = 1'b1;
    @(negedge C);
    chk_idle("mid_abort");
    clr = 1'b0;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge C);
      chk_idle("mid_no_done");
    end
    start_frame(8'h81);
    check_frame(8'h81, 1'b0, '0, 0);
  endtask

  task automatic test_random();
    logic [DB-1:0] d;
    int poke;
    int gap;
    for (int n = 0; n < 12; n++) begin
      d    = DB'($urandom);
      poke = ($urandom_range(0, 1) == 1) ?
             int'($urandom_range(2, NCYC)) : 0;
      start_frame(d);
      check_frame(d, 1'b0, '0, poke);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge C);
        chk_idle("rand_gap");
      end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    start_frame(8'h07);
    check_frame(8'h07, 1'b0, '0, 0);
    start_frame(8'h03);
    check_frame(8'h03, 1'b0, '0, 0);
  endtask
`endif

  initial begin
    clr  = 1'b1;
    load = 1'b0;
    D    = '0;
    test_reset();
    test_single();
    test_load_busy();
    test_back_to_back();
    test_mid_reset();
`ifdef PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter: DATA_BITS, default 8, payload bits per frame; legal range 5..8.
REQ-003 Port: C  input  1  system clock; all state updates on rising edge.
REQ-004 Port: clr  input  1  reset, synchronous, active-high.
REQ-005 Port: D  input  DATA_BITS  payload to transmit; sampled only on an accepted load.
REQ-006 Port: load  input  1  request to start a frame.
REQ-007 Port: ready  output  1  high when a load will be accepted.
REQ-008 Port: TX  output  1  serial line; idles high.
REQ-009 Port: busy  output  1  high while a frame is in progress; always equal to NOT ready.
REQ-010 Port: done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY (present only when PARITY_EN is defined), and STOP.
REQ-012 A load SHALL be accepted on a rising edge where load=1 and ready=1: D is copied into the shift register, the bit counter and cycle counter are cleared, and the state becomes START.
REQ-013 load while ready=0 SHALL be ignored: no requeue and no corruption of the frame in flight.
REQ-014 TX SHALL be registered: 1 in IDLE, 0 in START, shift_reg[0] in DATA, the parity bit in PARITY, and 1 in STOP.
REQ-015 TX SHALL go low on the first cycle after acceptance, giving a latency of one clock.
REQ-016 Each non-IDLE state SHALL hold for exactly CLKS_PER_BIT cycles, timed by a cycle counter that counts 0..CLKS_PER_BIT-1 and then wraps to 0 on the state or bit advance.
REQ-017 DATA SHALL shift the payload out LSB first, shifting right once per bit period, for exactly DATA_BITS periods, then advance to PARITY or STOP.
REQ-018 The parity bit SHALL be the even parity (XOR) of the DATA_BITS payload bits latched at acceptance.
REQ-019 done SHALL be 1 only on the final cycle of STOP; on the next edge the state SHALL be IDLE and ready SHALL be 1.
REQ-020 A load asserted during the done cycle SHALL be ignored, because ready=0 in that cycle.
REQ-021 Total frame length from the first TX=0 cycle to the first ready=1 cycle SHALL be (DATA_BITS+2)*CLKS_PER_BIT cycles, or (DATA_BITS+3)*CLKS_PER_BIT cycles with PARITY_EN defined.
REQ-022 Back-to-back frames: a load held high continuously SHALL be accepted on the first cycle ready=1, producing no extra idle bit beyond that single IDLE cycle.
REQ-023 D changing during a frame SHALL NOT affect the transmitted bits.

Reset
REQ-024 While clr=1 at a rising edge, the next state SHALL be: state IDLE, TX=1, ready=1, busy=0, done=0, counters 0, shift register 0.
REQ-025 clr asserted mid-frame SHALL abort the frame; TX SHALL return to 1 on the next edge, and done SHALL NOT pulse for the aborted frame.
REQ-026 clr SHALL take priority over load on the same edge.
REQ-027 No output SHALL change asynchronously to C.

Configuration
REQ-028 Macro PARITY_EN: when defined, the PARITY state SHALL be inserted between DATA and STOP, carrying even parity for one bit period.
REQ-029 When PARITY_EN is not defined, DATA SHALL go directly to STOP, no parity logic SHALL be synthesized, and frames SHALL be DATA_BITS+2 bits long.

Verification (CLKS_PER_BIT=4, DATA_BITS=8)
REQ-030 Reset then idle: clr=1 for 2 cycles, then 0 -> TX=1, ready=1, busy=0, done=0 held for 20 cycles.
REQ-031 Single frame: load=1 for one cycle with D=8'hA5 -> TX reads 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles; done=1 at cycle 40 after acceptance; ready=1 at cycle 41. With PARITY_EN the parity bit is 0 and done occurs at cycle 44.
REQ-032 Load while busy: accept D=8'h0F, then pulse load with D=8'hFF at cycle 10 -> the transmitted bits match 8'h0F only, and exactly one done pulse occurs.
REQ-033 Back-to-back: load held at 1 with D=8'h55, then D=8'h33 -> the second start bit begins 2 cycles after the first done pulse, and both payloads are bit-exact.
REQ-034 Mid-frame reset: clr=1 at cycle 17 of a D=8'h00 frame -> TX=1 and ready=1 on the next edge, no done pulse, and a following frame with D=8'h81 is transmitted correctly.
REQ-035 Parity check, PARITY_EN defined: D=8'h07 -> parity bit 1; D=8'h03 -> parity bit 0.
